// File: rtl/vga_color_pipe.sv
// vga_color_pipe: two-stage pixel colouriser feeding the VGA DAC.
// S1 registers the pixel and does the palette read; S2 expands the colour,
// applies the fade brightness and blanks outside active video.
module vga_color_pipe #(
    parameter int unsigned IN_W     = 8,
    parameter int unsigned CH_W     = 4,
    parameter int unsigned BR_W     = 4,
    parameter int unsigned FADE_DIV = 2
) (
    input  logic                clk_25m,
    input  logic                rst_n,
    input  logic                valid,
    input  logic [IN_W-1:0]     screen_data,
    input  logic [1:0]          mode,
    input  logic                pal_we,
    input  logic [IN_W-1:0]     pal_addr,
    input  logic [3*CH_W-1:0]   pal_wdata,
    input  logic                frame_tick,
    input  logic                fade_start,
    input  logic                fade_dir,
    output logic [3*CH_W-1:0]   rgb,
    output logic                rgb_valid,
    output logic                fade_busy,
    output logic                fade_done
);

    localparam int unsigned RGB_W  = 3 * CH_W;
    localparam int unsigned GREY_W = (CH_W < IN_W) ? CH_W : IN_W;
    localparam int unsigned PROD_W = CH_W + BR_W + 1;
    localparam int unsigned DIV_W  = $clog2(FADE_DIV + 1);

    localparam logic [BR_W:0]    LVL_FULL = {1'b1, {BR_W{1'b0}}};
    localparam logic [BR_W:0]    LVL_ZERO = '0;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FADE_DIV);

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        FADE_IN
    } fade_state_t;

    // Palette storage and S1 pipeline registers
    logic [RGB_W-1:0] r_pal [0:(1<<IN_W)-1];
    logic [RGB_W-1:0] r_s1_pal;
    logic [IN_W-1:0]  r_s1_data;
    logic             r_s1_valid;
    logic [1:0]       r_s1_mode;

    // Fade engine state
    fade_state_t      r_state;
    fade_state_t      w_state_nx;
    logic [BR_W:0]    r_level;
    logic [BR_W:0]    w_level_nx;
    logic [BR_W:0]    w_target;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nx;
    logic [DIV_W-1:0] w_div_inc;
    logic             r_done;
    logic             w_done_nx;

    // Colour expansion wires
    logic [3*CH_W-1:0]      w_rep_c0;
    logic [3*CH_W-1:0]      w_rep_c1;
    logic [2*CH_W-1:0]      w_rep_c2;
    logic [GREY_W*CH_W-1:0] w_rep_grey;
    logic [CH_W-1:0]        w_c0;
    logic [CH_W-1:0]        w_c1;
    logic [CH_W-1:0]        w_c2;

    // Palette write and synchronous read; read-during-write returns the old entry
    always_ff @(posedge clk_25m) begin
        if (pal_we) begin
            r_pal[pal_addr] <= pal_wdata;
        end
        r_s1_pal <= r_pal[screen_data];
    end

    // S1: capture pixel code, qualifier and mode
    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= '0;
        end else begin
            r_s1_valid <= valid;
            r_s1_data  <= screen_data;
            r_s1_mode  <= mode;
        end
    end

    // Field widening by repetition: the top CH_W bits of the repeated field
    // give MSB-first bit replication (abc -> abca, ab -> abab).
    assign w_rep_c0   = {CH_W{r_s1_data[7:5]}};
    assign w_rep_c1   = {CH_W{r_s1_data[4:2]}};
    assign w_rep_c2   = {CH_W{r_s1_data[1:0]}};
    assign w_rep_grey = {CH_W{r_s1_data[IN_W-1 -: GREY_W]}};

    // Channel selection by the per-pixel mode carried through S1
    always_comb begin
        w_c0 = w_rep_c0[3*CH_W-1 -: CH_W];
        w_c1 = w_rep_c1[3*CH_W-1 -: CH_W];
        w_c2 = w_rep_c2[2*CH_W-1 -: CH_W];
        case (r_s1_mode)
            2'd1: begin
                w_c0 = r_s1_pal[CH_W-1:0];
                w_c1 = r_s1_pal[2*CH_W-1:CH_W];
                w_c2 = r_s1_pal[3*CH_W-1:2*CH_W];
            end
            2'd2: begin
                w_c0 = w_rep_grey[GREY_W*CH_W-1 -: CH_W];
                w_c1 = w_rep_grey[GREY_W*CH_W-1 -: CH_W];
                w_c2 = w_rep_grey[GREY_W*CH_W-1 -: CH_W];
            end
            default: begin
            end
        endcase
    end

    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                              input logic [BR_W:0]   lvl);
        logic [PROD_W-1:0] p;
        p = PROD_W'(c) * PROD_W'(lvl);
        return p[BR_W +: CH_W];
    endfunction

    // S2: scale by brightness and blank outside active video
    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            rgb       <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb_valid <= r_s1_valid;
            if (r_s1_valid) begin
                rgb <= {scale(w_c2, r_level), scale(w_c1, r_level), scale(w_c0, r_level)};
            end else begin
                rgb <= '0;
            end
        end
    end

    // Fade engine state register
    always_ff @(posedge clk_25m) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_level <= LVL_FULL;
            r_div   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_level <= w_level_nx;
            r_div   <= w_div_nx;
            r_done  <= w_done_nx;
        end
    end

    assign w_div_inc = r_div + 1'b1;
    assign w_target  = (r_state == FADE_IN) ? LVL_FULL : LVL_ZERO;

    // Fade next-state: frame ticks are divided, each step moves level by one,
    // and reaching the target (or starting there) completes the fade.
    always_comb begin
        w_state_nx = r_state;
        w_level_nx = r_level;
        w_div_nx   = r_div;
        w_done_nx  = 1'b0;
        case (r_state)
            IDLE: begin
                if (fade_start) begin
                    w_state_nx = fade_dir ? FADE_IN : FADE_OUT;
                    w_div_nx   = '0;
                end
            end
            default: begin
                if (frame_tick) begin
                    if (w_div_inc == DIV_LAST) begin
                        w_div_nx = '0;
                        if (r_level == w_target) begin
                            w_state_nx = IDLE;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_level_nx = (r_state == FADE_IN) ? r_level + 1'b1
                                                              : r_level - 1'b1;
                            if (w_level_nx == w_target) begin
                                w_state_nx = IDLE;
                                w_done_nx  = 1'b1;
                            end
                        end
                    end else begin
                        w_div_nx = w_div_inc;
                    end
                end
            end
        endcase
    end

    assign fade_busy = (r_state != IDLE);
    assign fade_done = r_done;

endmodule

// File: tb/tb_vga_color_pipe.sv
// Scoreboard bench for vga_color_pipe (IN_W=8, CH_W=4, BR_W=4, FADE_DIV=1).
module tb_vga_color_pipe;

    logic        clk_25m = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [7:0]  screen_data;
    logic [1:0]  mode;
    logic        pal_we;
    logic [7:0]  pal_addr;
    logic [11:0] pal_wdata;
    logic        frame_tick;
    logic        fade_start;
    logic        fade_dir;
    logic [11:0] rgb;
    logic        rgb_valid;
    logic        fade_busy;
    logic        fade_done;

    typedef struct {
        int          due;
        int          id;
        logic        v;
        logic [11:0] rgb;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   n_id  = 0;

    vga_color_pipe #(
        .IN_W    (8),
        .CH_W    (4),
        .BR_W    (4),
        .FADE_DIV(1)
    ) dut (
        .clk_25m    (clk_25m),
        .rst_n      (rst_n),
        .valid      (valid),
        .screen_data(screen_data),
        .mode       (mode),
        .pal_we     (pal_we),
        .pal_addr   (pal_addr),
        .pal_wdata  (pal_wdata),
        .frame_tick (frame_tick),
        .fade_start (fade_start),
        .fade_dir   (fade_dir),
        .rgb        (rgb),
        .rgb_valid  (rgb_valid),
        .fade_busy  (fade_busy),
        .fade_done  (fade_done)
    );

    always #20 clk_25m = ~clk_25m;

    always @(posedge clk_25m) cyc <= cyc + 1;

    // Monitor: pop every expectation that falls due at this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_25m);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                total++;
                if (e.due != cyc || rgb_valid !== e.v || rgb !== e.rgb) begin
                    bad++;
                    $display("FAIL pix%0d: got valid=%b rgb=%h, want valid=%b rgb=%h (due %0d, now %0d)",
                             e.id, rgb_valid, rgb, e.v, e.rgb, e.due, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Drive one pixel cycle; optionally push its expected output two edges later
    task automatic step(input logic v, input logic [7:0] d, input logic [1:0] m,
                        input logic tk, input logic fs, input logic fd,
                        input logic push, input logic ev, input logic [11:0] er);
        exp_t e;
        valid       = v;
        screen_data = d;
        mode        = m;
        frame_tick  = tk;
        fade_start  = fs;
        fade_dir    = fd;
        if (push) begin
            e.due = cyc + 2;
            e.id  = n_id;
            e.v   = ev;
            e.rgb = er;
            n_id++;
            q.push_back(e);
        end
        @(negedge clk_25m);
        pal_we     = 1'b0;
        frame_tick = 1'b0;
        fade_start = 1'b0;
    endtask

    initial begin
        logic [3:0] lv;
        rst_n       = 1'b0;
        valid       = 1'b0;
        screen_data = 8'hFF;
        mode        = 2'd0;
        pal_we      = 1'b0;
        pal_addr    = '0;
        pal_wdata   = '0;
        frame_tick  = 1'b0;
        fade_start  = 1'b0;
        fade_dir    = 1'b0;
        repeat (3) @(negedge clk_25m);

        chk("reset_rgb", rgb, 12'h000);
        chk("reset_rgb_valid", {11'd0, rgb_valid}, 12'd0);
        chk("reset_busy", {11'd0, fade_busy}, 12'd0);
        chk("reset_done", {11'd0, fade_done}, 12'd0);
        rst_n = 1'b1;

        // Direct mode expansion
        step(1, 8'hFF, 2'd0, 0, 0, 0, 1, 1, 12'hFFF);
        step(1, 8'hA9, 2'd0, 0, 0, 0, 1, 1, 12'h54B);
        step(1, 8'h00, 2'd0, 0, 0, 0, 1, 1, 12'h000);
        step(1, 8'hFF, 2'd3, 0, 0, 0, 1, 1, 12'hFFF);

        // Blanking in every mode
        step(0, 8'hFF, 2'd0, 0, 0, 0, 1, 0, 12'h000);
        step(0, 8'hFF, 2'd1, 0, 0, 0, 1, 0, 12'h000);
        step(0, 8'hFF, 2'd2, 0, 0, 0, 1, 0, 12'h000);

        // Palette write then read
        pal_we = 1'b1; pal_addr = 8'h03; pal_wdata = 12'hA5C;
        step(0, 8'h00, 2'd1, 0, 0, 0, 1, 0, 12'h000);
        step(1, 8'h03, 2'd1, 0, 0, 0, 1, 1, 12'hA5C);
        pal_we = 1'b1; pal_addr = 8'h07; pal_wdata = 12'h456;
        step(0, 8'h00, 2'd1, 0, 0, 0, 1, 0, 12'h000);
        // Same-cycle read and write of address 07 returns the old entry
        pal_we = 1'b1; pal_addr = 8'h07; pal_wdata = 12'h123;
        step(1, 8'h07, 2'd1, 0, 0, 0, 1, 1, 12'h456);
        step(1, 8'h07, 2'd1, 0, 0, 0, 1, 1, 12'h123);

        // Grey mode, then per-pixel mode switch back to direct
        step(1, 8'hC3, 2'd2, 0, 0, 0, 1, 1, 12'hCCC);
        step(1, 8'hA9, 2'd0, 0, 0, 0, 1, 1, 12'h54B);
        step(1, 8'h5A, 2'd2, 0, 0, 0, 1, 1, 12'h555);

        // Fade out from full: after n ticks level is 16-n, channel 15-n
        step(1, 8'hFF, 2'd0, 0, 1, 0, 1, 1, 12'hFFF);
        chk("fade_out_busy", {11'd0, fade_busy}, 12'd1);
        for (int n = 1; n <= 16; n++) begin
            lv = (n < 16) ? 4'(15 - n) : 4'd0;
            step(1, 8'hFF, 2'd0, 1, 0, 0, 1, 1, {lv, lv, lv});
            if (n < 16) begin
                chk("fade_out_done_low", {11'd0, fade_done}, 12'd0);
            end
            if (n == 3) begin
                // Fade-in request while busy must be ignored: level stays 13
                step(1, 8'hFF, 2'd0, 0, 1, 1, 1, 1, 12'hCCC);
                chk("ignored_start_busy", {11'd0, fade_busy}, 12'd1);
            end
        end
        chk("fade_out_done_pulse", {11'd0, fade_done}, 12'd1);
        chk("fade_out_busy_low", {11'd0, fade_busy}, 12'd0);
        step(1, 8'hFF, 2'd0, 0, 0, 0, 1, 1, 12'h000);
        chk("fade_out_done_one_cycle", {11'd0, fade_done}, 12'd0);

        // Fade out while already black completes on first step attempt
        step(1, 8'hFF, 2'd0, 0, 1, 0, 1, 1, 12'h000);
        chk("at_target_busy", {11'd0, fade_busy}, 12'd1);
        step(1, 8'hFF, 2'd0, 1, 0, 0, 1, 1, 12'h000);
        chk("at_target_done", {11'd0, fade_done}, 12'd1);
        chk("at_target_busy_low", {11'd0, fade_busy}, 12'd0);

        // Fade in from 0, interrupted by reset after 5 ticks
        step(1, 8'hFF, 2'd0, 0, 1, 1, 1, 1, 12'h000);
        chk("fade_in_busy", {11'd0, fade_busy}, 12'd1);
        for (int n = 1; n <= 5; n++) begin
            lv = 4'(n - 1);
            step(1, 8'hFF, 2'd0, 1, 0, 0, 1, 1, {lv, lv, lv});
        end
        step(0, 8'hFF, 2'd0, 0, 0, 0, 1, 0, 12'h000);
        step(0, 8'hFF, 2'd0, 0, 0, 0, 1, 0, 12'h000);
        rst_n = 1'b0;
        step(0, 8'hFF, 2'd0, 0, 0, 0, 0, 0, 12'h000);
        chk("mid_fade_reset_busy", {11'd0, fade_busy}, 12'd0);
        chk("mid_fade_reset_done", {11'd0, fade_done}, 12'd0);
        rst_n = 1'b1;
        step(1, 8'hFF, 2'd0, 0, 0, 0, 1, 1, 12'hFFF);
        chk("post_reset_done", {11'd0, fade_done}, 12'd0);
        step(1, 8'hFF, 2'd0, 1, 0, 0, 1, 1, 12'hFFF);
        chk("post_reset_busy", {11'd0, fade_busy}, 12'd0);
        step(1, 8'hFF, 2'd0, 0, 0, 0, 1, 1, 12'hFFF);
        chk("post_reset_done2", {11'd0, fade_done}, 12'd0);

        repeat (4) step(0, 8'h00, 2'd0, 0, 0, 0, 0, 0, 12'h000);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
